// File: rtl/bram_port_ctrl.sv
// Request/response front end for a dual-port byte-enable block RAM.
// Writes pass straight through. Reads are credit-limited into a 2-entry in-order response buffer.
module bram_port_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [BE_WIDTH-1:0]   ram_be,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    logic                  inflight;
    logic [1:0]            count;
    logic [1:0]            count_nxt;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [DATA_WIDTH-1:0] rsp_buf [2];

    logic                  pop;
    logic                  push;
    logic                  collision;
    logic [2:0]            occupancy;

    always_comb begin
        pop       = rsp_valid & rsp_ready;
        push      = inflight;
        // Slots committed after this edge: buffered + arriving - leaving.
        occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        collision = wr_valid & rd_valid & (rd_addr == wr_addr);

        wr_ready    = rst_n;
        rd_ready    = rst_n & ~collision & (occupancy < 3'd2);

        ram_we      = wr_valid & wr_ready;
        ram_wr_addr = wr_addr;
        ram_di      = wr_data;
        ram_be      = wr_be;

        ram_re      = rd_valid & rd_ready;
        ram_rd_addr = rd_addr;

        rsp_data    = rsp_buf[rd_ptr];

        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            inflight  <= ram_re;
            count     <= count_nxt;
            rsp_valid <= (count_nxt != 2'd0);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Buffer storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rsp_buf[wr_ptr] <= ram_do;
        end
    end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Directed bench for bram_port_ctrl with a behavioural byte-enable RAM attached.
// Ends with a short randomised phase checked against a reference memory.
module tb_bram_port_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [BW-1:0] wr_be = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_wr_addr;
    logic [BW-1:0] ram_be;
    logic          ram_we;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_re;
    logic [DW-1:0] ram_do = '0;

    logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_di(ram_di), .ram_wr_addr(ram_wr_addr), .ram_be(ram_be), .ram_we(ram_we),
        .ram_rd_addr(ram_rd_addr), .ram_re(ram_re), .ram_do(ram_do)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < BW; b++) begin
                if (ram_be[b]) ram[ram_wr_addr][8*b +: 8] <= ram_di[8*b +: 8];
            end
        end
        if (ram_re) ram_do <= ram[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [DW-1:0] refm [0:7];
    logic [DW-1:0] expq [$];

    initial begin
        int naccept;
        int got;
        logic acc;

        // Reset state with requests already presented
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 10'd3; rd_addr = 10'd4;
        smp();
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_rd_ready", rd_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk1("rst_ram_re", ram_re, 1'b0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        smp();
        rst_n = 1'b1;
        #1;
        chk1("wr_ready_after_rst", wr_ready, 1'b1);
        tick();

        // Byte-enable merge then read-back
        wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 32'h1122_3344; wr_be = 4'b1111;
        smp();
        chk1("wr1_ram_we", ram_we, 1'b1);
        tick();
        wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
        smp();
        chk("wr2_ram_be", 32'(ram_be), 32'h5);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'd5;
        smp();
        chk1("rd5_ready", rd_ready, 1'b1);
        chk1("rd5_ram_re", ram_re, 1'b1);
        tick();
        rd_valid = 1'b0;
        smp();
        chk1("rd5_t1_valid", rsp_valid, 1'b0);
        tick();
        smp();
        chk1("rd5_t2_valid", rsp_valid, 1'b1);
        chk("rd5_t2_data", rsp_data, 32'h11BB_33DD);
        tick();
        rsp_ready = 1'b1;
        smp();
        chk1("rd5_hold_valid", rsp_valid, 1'b1);
        chk("rd5_hold_data", rsp_data, 32'h11BB_33DD);
        tick();
        smp();
        chk1("rd5_popped", rsp_valid, 1'b0);
        tick();

        // Same-address write/read collision
        wr_valid = 1'b1; wr_addr = 10'd7; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
        rd_valid = 1'b1; rd_addr = 10'd7;
        smp();
        chk1("col_rd_ready", rd_ready, 1'b0);
        chk1("col_ram_re", ram_re, 1'b0);
        chk1("col_ram_we", ram_we, 1'b1);
        tick();
        wr_valid = 1'b0;
        smp();
        chk1("col_retry_ready", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        tick();
        smp();
        chk1("col_rsp_valid", rsp_valid, 1'b1);
        chk("col_rsp_data", rsp_data, 32'hCAFE_F00D);
        tick();
        tick();

        // Back-pressure: two credits, then drain in order
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 32'hA000_0000 + 32'(i); wr_be = 4'hF;
            tick();
        end
        wr_valid = 1'b0;
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd0;
        naccept = 0;
        for (int c = 0; c < 5; c++) begin
            smp();
            chk1($sformatf("bp_rd_ready_c%0d", c), rd_ready, (c < 2));
            acc = rd_ready;
            tick();
            if (acc) begin
                naccept++;
                rd_addr = AW'(naccept);
            end
        end
        chk("bp_accepted", 32'(naccept), 32'd2);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            smp();
            if (rsp_valid) begin
                chk($sformatf("bp_rsp%0d", got), rsp_data, 32'hA000_0000 + 32'(got));
                got++;
            end
            acc = rd_valid & rd_ready;
            tick();
            if (acc) begin
                naccept++;
                rd_addr = AW'(naccept);
                if (naccept == 4) rd_valid = 1'b0;
            end
        end
        chk("bp_responses", 32'(got), 32'd4);
        tick();

        // Streaming 16 reads
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 32'h1000_0000 | 32'(i); wr_be = 4'hF;
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            rd_valid = (i < 16);
            rd_addr = AW'(i);
            smp();
            if (i < 16) chk1($sformatf("str_ready%0d", i), rd_ready, 1'b1);
            if (i >= 2) begin
                chk1($sformatf("str_valid%0d", i), rsp_valid, 1'b1);
                chk($sformatf("str_data%0d", i), rsp_data, 32'h1000_0000 | 32'(i - 2));
            end else begin
                chk1($sformatf("str_valid%0d", i), rsp_valid, 1'b0);
            end
            tick();
        end
        rd_valid = 1'b0;
        smp();
        chk1("str_done", rsp_valid, 1'b0);
        tick();

        // Reset with a buffered and an in-flight read
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd0;
        tick();
        rd_addr = 10'd1;
        tick();
        rd_valid = 1'b0;
        smp();
        chk1("mid_pre_valid", rsp_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", rsp_valid, 1'b0);
        chk1("mid_rst_rd_ready", rd_ready, 1'b0);
        tick();
        tick();
        smp();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            smp();
            chk1($sformatf("mid_no_stale%0d", c), rsp_valid, 1'b0);
        end
        tick();
        rd_valid = 1'b1; rd_addr = 10'd3;
        tick();
        rd_valid = 1'b0;
        tick();
        smp();
        chk("mid_ram_kept", rsp_data, 32'h1000_0003);
        tick();

        // Random traffic on a small address window
        for (int i = 0; i < 8; i++) refm[i] = 32'h1000_0000 | 32'(i);
        for (int n = 0; n < 300; n++) begin
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, 7));
            wr_data   = $urandom;
            wr_be     = BW'($urandom_range(0, 15));
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = AW'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
            smp();
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) chk1("rnd_spurious", rsp_valid, 1'b0);
                else chk("rnd_data", rsp_data, expq.pop_front());
            end
            chk1("rnd_collision", ram_we & ram_re & (ram_wr_addr == ram_rd_addr), 1'b0);
            if (rd_valid && rd_ready) expq.push_back(refm[rd_addr[2:0]]);
            if (wr_valid) begin
                for (int b = 0; b < BW; b++) begin
                    if (wr_be[b]) refm[wr_addr[2:0]][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (rsp_valid) begin
                if (expq.size() == 0) chk1("rnd_drain_spurious", rsp_valid, 1'b0);
                else chk("rnd_drain_data", rsp_data, expq.pop_front());
            end
            tick();
        end
        chk("rnd_outstanding", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
